// File: rtl/sixbit_alu_pkg.sv
// Shared constants for the 6-bit ALU operand path: operand width,
// loader FSM state encoding and the 3-bit ALU operation codes.
package sixbit_alu_pkg;

  localparam int WIDTH = 6;
  localparam int OP_W  = 3;

  // Loader FSM; encoding is shown on the state LEDs so it is fixed.
  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    ISSUE   = 2'd3
  } ld_state_e;

  // Operation select presented to the ALU bit-slice gates.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/sixbit_operand_loader_if.sv
// Operand/op issue handshake between the loader and the ALU result stage.
interface sixbit_operand_loader_if #(
  parameter int WIDTH = sixbit_alu_pkg::WIDTH
);
  import sixbit_alu_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             valid;
  logic             ready;

  modport master (output a, b, op, valid, input ready);
  modport slave  (input a, b, op, valid, output ready);
endinterface

// File: rtl/sixbit_operand_loader_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-count debouncer and a
// single-cycle pulse on each accepted press (nothing on release).
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, then accept a new level only after DB_CYCLES mismatching cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          pulse_q <= sync2_q;   // rising acceptance only
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/sixbit_operand_loader.sv
// Loads operand A, operand B and the ALU op from the switches on three
// debounced load presses, then holds them valid until the ALU accepts.
module sixbit_operand_loader
  import sixbit_alu_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int WIDTH     = sixbit_alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [OP_W-1:0]  op,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       state
);
  logic load_pulse, clr_pulse;

  ld_state_e        state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OP_W-1:0]  op_q;
  logic             valid_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_load),
    .pulse_o (load_pulse)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_clr),
    .pulse_o (clr_pulse)
  );

  // Loader FSM; clear wins over load and handshake, valid is registered with the ISSUE state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else if (clr_pulse) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: if (load_pulse) begin
          a_q     <= sw;
          state_q <= WAIT_B;
        end
        WAIT_B: if (load_pulse) begin
          b_q     <= sw;
          state_q <= WAIT_OP;
        end
        WAIT_OP: if (load_pulse) begin
          op_q    <= sw[OP_W-1:0];
          state_q <= ISSUE;
          valid_q <= 1'b1;
        end
        ISSUE: if (ready) begin   // loads here are dropped, operands hold
          state_q <= WAIT_A;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= WAIT_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign op    = op_q;
  assign valid = valid_q;
  assign state = state_q;
endmodule

// File: doc/sixbit_operand_loader.md
SIXBIT_OPERAND_LOADER -- requirements
Module: sixbit_operand_loader

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, giving the number of consecutive stable cycles needed before a button level is accepted.
REQ-002 SHALL have parameter WIDTH, default 6, giving the operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sw, input, WIDTH bits: raw switch value.
REQ-006 SHALL have port btn_load, input, 1 bit: raw, asynchronous, bouncing load button.
REQ-007 SHALL have port btn_clr, input, 1 bit: raw, asynchronous, bouncing clear button.
REQ-008 SHALL have port a, output, WIDTH bits: registered operand A for the ALU bit-slice gates.
REQ-009 SHALL have port b, output, WIDTH bits: registered operand B.
REQ-010 SHALL have port op, output, 3 bits: registered ALU operation select, taken from sw[2:0].
REQ-011 SHALL have port valid, output, 1 bit: a, b and op form a complete operation.
REQ-012 SHALL have port ready, input, 1 bit: the downstream ALU/result stage accepts the operation.
REQ-013 SHALL have port state, output, 2 bits: current FSM state, for LED display.

Function
REQ-014 SHALL pass btn_load and btn_clr each through a 2-flop synchronizer, then a debouncer.
REQ-015 Debouncer SHALL change its accepted level only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-016 Debouncer SHALL emit a 1-cycle pulse on each accepted 0->1 transition; there SHALL be no pulse on release.
REQ-017 Latency from a clean raw edge to the pulse SHALL be 2 + DB_CYCLES cycles.
REQ-018 FSM states SHALL be WAIT_A=0, WAIT_B=1, WAIT_OP=2, ISSUE=3.
REQ-019 WAIT_A + load pulse: a <= sw, go to WAIT_B.
REQ-020 WAIT_B + load pulse: b <= sw, go to WAIT_OP.
REQ-021 WAIT_OP + load pulse: op <= sw[2:0], go to ISSUE.
REQ-022 valid SHALL equal 1 exactly while in ISSUE, as a registered state decode with no combinational path from ready.
REQ-023 ISSUE with ready=1 SHALL complete the handshake in that cycle and go to WAIT_A the next cycle; a, b and op SHALL hold their values.
REQ-024 While in ISSUE, a, b and op SHALL remain stable until the handshake, whatever ready does.
REQ-025 A load pulse in ISSUE SHALL be ignored and SHALL NOT be queued.
REQ-026 A clr pulse in any state SHALL clear a, b and op to 0 and force WAIT_A next cycle, taking priority over a simultaneous load pulse or handshake.
REQ-027 ready in states other than ISSUE SHALL have no effect.
REQ-028 A held button SHALL generate only one pulse, i.e. advance the FSM by only one state.

Reset
REQ-029 reset_n=0 SHALL asynchronously set a=0, b=0, op=0, valid=0, state=WAIT_A, and clear synchronizers, debounce counters, accepted levels and pulses.
REQ-030 Reset mid-operation, including in ISSUE, SHALL discard the pending operation; valid SHALL drop immediately.
REQ-031 Release of reset_n SHALL be the only way out of reset; the first pulse SHALL require a full debounce period after release.

Structure
REQ-032 Package sixbit_alu_pkg SHALL hold WIDTH=6, the FSM state encoding and the 3-bit ALU op codes (including the XNOR op code).
REQ-033 SHALL contain one sub-module, btn_debounce (synchronizer, counter, pulse), instantiated for btn_load and btn_clr.
REQ-034 Target size SHALL be 120-400 lines of RTL in total.

Verification (DB_CYCLES=4 for simulation)
REQ-035 Full sequence: sw=6'b101100 press, sw=6'b011010 press, sw=3'b101 press, ready=1 -> a=101100, b=011010, op=101, valid high for exactly 1 cycle, state back to 0.
REQ-036 Bounce: btn_load toggled every cycle for 10 cycles, then held high -> exactly one pulse, 6 cycles after the hold starts; state 0->1 only.
REQ-037 Backpressure: ISSUE with ready=0 for 20 cycles plus one extra load press -> valid stays 1, a/b/op unchanged; ready=1 -> state 0.
REQ-038 Clear priority: in WAIT_OP, clr and load pulses in the same cycle -> a=b=op=0, state=WAIT_A, op not loaded.
REQ-039 Async reset: reset_n driven low mid-cycle while in ISSUE -> valid=0 and all outputs 0 before the next clk edge.
REQ-040 Held button: btn_load held high for 100 cycles -> exactly one state advance.
